data_memory_unit: RTL and testbench

// - Word-addressed data RAM for the single-cycle ARM datapath; serves LDR/STR from the ALU-computed address.
// - Write is synchronous on the rising CLK edge; read is combinational, so a load completes in the same cycle.
// - Sits between the ALU result (Address), the register-file read port (WriteData) and the writeback mux (ReadData).

---
 rtl/data_memory_unit.sv | 85 ++++++++
 tb/tb_data_memory_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
`default_nettype none
//==============================================================================
// Module      : data_memory_unit
// Description : Word-addressed data RAM for the single-cycle ARM datapath.
//               Synchronous write on rising CLK, combinational read, so a
//               load completes in the same cycle as its address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters:
//   DEPTH   - number of DATA_W-bit words (power of two, >= 2)
//   ADDR_W  - byte-address width of Address
//   DATA_W  - word width of WriteData / ReadData
// Ports:
//   CLK        in   1       rising-edge clock
//   RST_N      in   1       synchronous active-low reset, clears every word
//   Address    in   ADDR_W  byte address; word index = Address[IDX_W+1:2]
//   WriteData  in   DATA_W  store data
//   MemWrite   in   1       store enable, written on the next rising CLK
//   ReadData   out  DATA_W  load data (combinational, 0 when out of range)
//   AccessErr  out  1       only with DMEM_ERR_EN: out of range or misaligned
// Configuration macro:
//   DMEM_ERR_EN - when defined, adds the AccessErr port and its logic.
//==============================================================================
module data_memory_unit #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] ReadData
`ifdef DMEM_ERR_EN
    ,
    output logic              AccessErr
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx_w;
    logic              in_range_w;

    // Byte lanes Address[1:0] never select a word; unaligned acts as aligned.
    assign idx_w = Address[IDX_W+1:2];

    // Any set bit above the index field means the address is outside the
    // array. The upper field only exists when the address is wider than the
    // index plus byte lanes.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_chk
            assign in_range_w = (Address[ADDR_W-1:IDX_W+2] == '0);
        end else begin : g_range_full
            assign in_range_w = 1'b1;
        end
    endgenerate

    // Reset has priority: a store presented during reset is dropped. Stores
    // outside the array are dropped rather than aliased onto a low word.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (MemWrite && in_range_w) begin
            mem_q[idx_w] <= WriteData;
        end
    end

    // No write bypass: a read during a store shows the old word until the edge.
    assign ReadData = in_range_w ? mem_q[idx_w] : '0;

`ifdef DMEM_ERR_EN
    assign AccessErr = !in_range_w | (Address[1:0] != 2'b00);
`else
    // Byte-lane bits only feed the error flag, which is absent in this build.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Address[1:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_data_memory_unit
// Description : Self-checking bench for data_memory_unit: a directed vector
//               table, a full reset sweep, a back-to-back store sequence and
//               randomized traffic compared against an array-based model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_data_memory_unit;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [ADDR_W-1:0] Address = '0;
    logic [DATA_W-1:0] WriteData = '0;
    logic              MemWrite = 1'b0;
    logic [DATA_W-1:0] ReadData;
`ifdef DMEM_ERR_EN
    logic              AccessErr;
`endif

    int checks = 0;
    int errors = 0;

    // Reference contents, indexed by word number.
    logic [DATA_W-1:0] model [DEPTH];

    data_memory_unit #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .ReadData (ReadData)
`ifdef DMEM_ERR_EN
        ,
        .AccessErr(AccessErr)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string             name;
        logic              rst_n;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              chk_before;
        logic [DATA_W-1:0] exp_before;
        logic [DATA_W-1:0] exp_after;
        logic              exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic r, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic w, input logic cb,
                           input logic [DATA_W-1:0] eb, input logic [DATA_W-1:0] ea,
                           input logic ee);
        vec_t v;
        v.name = n; v.rst_n = r; v.addr = a; v.wdata = d; v.we = w;
        v.chk_before = cb; v.exp_before = eb; v.exp_after = ea; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic check_err(input string n, input logic exp);
`ifdef DMEM_ERR_EN
        checks++;
        if (AccessErr !== exp) begin
            errors++;
            $display("FAIL %s AccessErr: got %b expected %b", n, AccessErr, exp);
        end
`else
        if (exp === 1'bx) $display("unreachable %s", n);
`endif
    endtask

    // Higher-level view of the memory: byte addresses below DEPTH*4 map to
    // word addr/4, everything else reads as zero and cannot be written.
    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (a < DEPTH * 4) return model[a / 4];
        return '0;
    endfunction

    function automatic logic ref_err(input logic [ADDR_W-1:0] a);
        return (a >= DEPTH * 4) || (a % 4 != 0);
    endfunction

    task automatic ref_edge(input logic r, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic w);
        if (!r) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (w && a < DEPTH * 4) begin
            model[a / 4] = d;
        end
    endtask

    // Drive on the falling edge, check combinational read, then check again
    // 1 time unit after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge CLK);
        RST_N = v.rst_n; Address = v.addr; WriteData = v.wdata; MemWrite = v.we;
        #1;
        if (v.chk_before) check({v.name, "/before"}, ReadData, v.exp_before);
        check_err(v.name, v.exp_err);
        @(posedge CLK);
        #1;
        check({v.name, "/after"}, ReadData, v.exp_after);
    endtask

    initial begin
        // Directed table: rows run in order, each one clock edge.
        add_vec("reset_drops_write", 0, 32'd0,  32'hDEAD_BEEF, 1, 0, 0, 32'h0, 0);
        add_vec("write_w0",          1, 32'd0,  32'h0000_0007, 1, 1, 0, 32'h7, 0);
        add_vec("inhibit_w0",        1, 32'd0,  32'h0000_0000, 0, 1, 32'h7, 32'h7, 0);
        add_vec("write_addr4",       1, 32'd4,  32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001, 0);
        add_vec("write_addr8",       1, 32'd8,  32'h5A5A_0002, 1, 1, 0, 32'h5A5A_0002, 0);
        add_vec("read_addr4",        1, 32'd4,  32'hFFFF_FFFF, 0, 1, 32'hA5A5_0001, 32'hA5A5_0001, 0);
        add_vec("read_unaligned5",   1, 32'd5,  32'hFFFF_FFFF, 0, 1, 32'hA5A5_0001, 32'hA5A5_0001, 1);
        add_vec("read_addr8",        1, 32'd8,  32'h0,         0, 1, 32'h5A5A_0002, 32'h5A5A_0002, 0);
        add_vec("out_of_range_wr",   1, DEPTH*4, 32'hCAFE_F00D, 1, 1, 0, 32'h0, 1);
        add_vec("w0_unchanged",      1, 32'd0,  32'h0,         0, 1, 32'h7, 32'h7, 0);
        add_vec("misaligned_wr_w1",  1, 32'd6,  32'h0BAD_0006, 1, 1, 32'hA5A5_0001, 32'h0BAD_0006, 1);
        add_vec("write_w3",          1, 32'd12, 32'h0000_1111, 1, 1, 0, 32'h1111, 0);
        add_vec("rdw_w3",            1, 32'd12, 32'h0000_2222, 1, 1, 32'h1111, 32'h2222, 0);
        add_vec("reset_w3",          0, 32'd12, 32'h0000_3333, 1, 1, 32'h2222, 32'h0, 0);

        // Let the power-on reset take at least one edge.
        @(posedge CLK);
        apply(vecs[0]);

        // Sweep after reset: every word reads zero.
        begin
            int bad = 0;
            RST_N = 1'b1; MemWrite = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                Address = i * 4;
                #1;
                if (ReadData !== '0) bad++;
            end
            check("reset_sweep_nonzero_words", bad, 0);
        end

        for (int i = 1; i < vecs.size(); i++) apply(vecs[i]);

        // Reference now matches the reset state left by the last row.
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Back-to-back stores to one word, then an aliasing probe above range.
        begin
            vec_t v;
            v.name = "b2b_first"; v.rst_n = 1; v.addr = 20; v.wdata = 32'h1; v.we = 1;
            v.chk_before = 1; v.exp_before = 0; v.exp_after = 32'h1; v.exp_err = 0;
            apply(v);
            v.name = "b2b_second"; v.wdata = 32'h2; v.exp_before = 32'h1; v.exp_after = 32'h2;
            apply(v);
            v.name = "alias_probe"; v.addr = DEPTH * 4 + 20; v.wdata = 32'h3;
            v.exp_before = 0; v.exp_after = 0; v.exp_err = 1;
            apply(v);
            @(negedge CLK);
            MemWrite = 0; Address = 20;
            #1;
            check("no_alias_w5", ReadData, 32'h2);
            model[5] = 32'h2;
        end

        // Randomized traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            logic              r, w;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            r = ($urandom_range(0, 39) != 0);
            w = $urandom_range(0, 1);
            d = $urandom;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = $urandom_range(0, DEPTH * 4 - 1);
            @(negedge CLK);
            RST_N = r; Address = a; WriteData = d; MemWrite = w;
            #1;
            check("rand_before", ReadData, ref_read(a));
            check_err("rand", ref_err(a));
            @(posedge CLK);
            ref_edge(r, a, d, w);
            #1;
            check("rand_after", ReadData, ref_read(a));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
